// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI slave front-end.
//   - FSM state codes (kept as plain localparam constants so they stay
//     compatible with older code that compares state against literals)
//   - Command codes carried in rx_data[9:8]
//   - Default frame, data and timeout sizes
package spi_ctrl_pkg;

  localparam int FRAME_W_DEF    = 10;
  localparam int DATA_W_DEF     = 8;
  localparam int TX_TIMEOUT_DEF = 16;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Bundle of the SPI pins and the memory-side handshake.
//   ss_n, mosi      : SPI master -> slave
//   miso            : slave -> SPI master
//   rx_data/rx_valid: slave -> memory (din / rx_valid)
//   tx_data/tx_valid: memory -> slave (dout / tx_valid)
// Modports: slave (the controller), master (pins + memory model driving it).
interface spi_slave_ctrl_if
  import spi_ctrl_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic               ss_n;
  logic               mosi;
  logic               miso;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_tx_shifter.sv
// MSB-first serialiser for read data returned on miso.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : drop any pending/in-progress transfer (slave deselected)
//   load       : capture din; its MSB appears on sout after this edge
//   din        : parallel data to send
//   sout       : serial output, 0 when idle
//   busy       : bits still being shifted out
//   done       : a full word has been sent since the last clear
module spi_tx_shifter
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W);

  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr   <= '0;
      cnt  <= '0;
      sout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      // MSB goes out immediately; cnt tracks the bits still to follow
      sout <= din[DATA_W-1];
      sr   <= {din[DATA_W-2:0], 1'b0};
      cnt  <= CW'(DATA_W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        sout <= sr[DATA_W-1];
        sr   <= {sr[DATA_W-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end else begin
        sout <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end sequencing a 256x8 memory.
// Receives 10-bit frames (cmd in bits [9:8]) MSB-first on mosi, presents
// them on rx_data with a one-cycle rx_valid pulse, and for read-data frames
// serialises the memory's tx_data onto miso once tx_valid arrives.
// Ports:
//   clk   : clock, also SCK; everything samples on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : spi_slave_ctrl_if.slave (ss_n, mosi, miso, rx_data, rx_valid,
//           tx_data, tx_valid)
// Build option: define SPI_TX_TIMEOUT_EN to bound the wait for tx_valid to
// TX_TIMEOUT cycles; without it the wait is unbounded and no counter exists.
module spi_slave_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
`ifdef SPI_TX_TIMEOUT_EN
  ,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF
`endif
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_W);

  logic [2:0]         state;
  logic [FRAME_W-2:0] shreg;        // bits taken so far, excluding the last
  logic [CNT_W-1:0]   bit_cnt;
  logic               frame_done;   // frame complete, ignore mosi until ss_n=1
  logic               rd_addr_done;
  logic [FRAME_W-1:0] rx_data_r;
  logic               rx_valid_r;

  logic tx_load, tx_busy, tx_done, tx_sout;
  logic wait_phase;
  logic timed_out;

  // Wait phase: read-data frame received, nothing loaded yet
  assign wait_phase = (state == READ_DATA) && frame_done &&
                      !tx_busy && !tx_done && !timed_out;
  assign tx_load    = wait_phase && bus.tx_valid && !bus.ss_n;

`ifdef SPI_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TX_TIMEOUT);

  logic [TO_W-1:0] to_cnt;
  logic            to_expire;

  assign to_expire = wait_phase && !bus.tx_valid && (to_cnt == TO_W'(TX_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || bus.ss_n) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (wait_phase && !bus.tx_valid) begin
      if (to_expire) timed_out <= 1'b1;
      else           to_cnt    <= to_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      frame_done   <= 1'b0;
      rd_addr_done <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
    end else if (bus.ss_n) begin
      // Deselect aborts the frame; rx_data and rd_addr_done are kept
      state      <= IDLE;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
`ifdef SPI_TX_TIMEOUT_EN
      if (to_expire) rd_addr_done <= 1'b0;
`endif
      case (state)
        IDLE: state <= CHK_CMD;
        CHK_CMD: begin
          // bit 9 alone picks the branch; a read frame is an address
          // frame unless one has already been latched
          shreg   <= {{(FRAME_W-2){1'b0}}, bus.mosi};
          bit_cnt <= CNT_W'(1);
          if (!bus.mosi)         state <= WRITE;
          else if (rd_addr_done) state <= READ_DATA;
          else                   state <= READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done) begin
            shreg   <= {shreg[FRAME_W-3:0], bus.mosi};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
              rx_data_r  <= {shreg, bus.mosi};
              rx_valid_r <= 1'b1;
              frame_done <= 1'b1;
              if (state == READ_ADD)  rd_addr_done <= 1'b1;
              if (state == READ_DATA) rd_addr_done <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.ss_n),
    .load  (tx_load),
    .din   (bus.tx_data),
    .sout  (tx_sout),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  assign bus.miso     = tx_sout;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: last completed frame and whether a read address is latched
  logic [9:0] m_rx;
  logic       m_rad;

  spi_slave_ctrl_if bus ();

  spi_slave_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ss_n high for n cycles; tx_valid toggled randomly to show it is ignored
  task automatic gap(input int n);
    bus.ss_n = 1'b1;
    repeat (n) begin
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = 8'($urandom);
      tick();
      chk("gap_rx_valid", bus.rx_valid, 0);
      chk("gap_miso", bus.miso, 0);
      chk("gap_rx_data", bus.rx_data, m_rx);
    end
    bus.tx_valid = 1'b0;
  endtask

  // Send nbits of frame f (10 = full frame, less = abort by ss_n)
  task automatic frame(input logic [9:0] f, input int nbits, output bit is_rd_data);
    bit rd_data;
    rd_data = f[9] && m_rad;
    is_rd_data = 1'b0;
    bus.ss_n = 1'b0;
    bus.mosi = 1'($urandom);
    tick();  // IDLE -> CHK_CMD
    for (int i = 0; i < nbits; i++) begin
      bus.mosi     = f[9-i];
      bus.tx_valid = 1'($urandom);
      tick();
      if (i == 9) begin
        m_rx = f;
        if (f[9]) m_rad = !rd_data;
        is_rd_data = rd_data;
        chk("frame_rx_valid_hi", bus.rx_valid, 1);
        chk("frame_rx_data", bus.rx_data, f);
        chk("frame_rd_addr_done", dut.rd_addr_done, m_rad);
      end else begin
        chk("frame_rx_valid_lo", bus.rx_valid, 0);
        chk("frame_rx_data_hold", bus.rx_data, m_rx);
      end
      chk("frame_miso", bus.miso, 0);
    end
    bus.tx_valid = 1'b0;
    if (nbits < 10) begin
      bus.ss_n = 1'b1;
      tick();
      chk("abort_rx_valid", bus.rx_valid, 0);
      chk("abort_rx_data", bus.rx_data, m_rx);
      chk("abort_rd_addr_done", dut.rd_addr_done, m_rad);
    end
  endtask

  // After completion mosi is ignored
  task automatic hold(input int n);
    repeat (n) begin
      bus.mosi = 1'($urandom);
      tick();
      chk("hold_rx_valid", bus.rx_valid, 0);
      chk("hold_rx_data", bus.rx_data, m_rx);
    end
  endtask

  // Memory answers after wait_n cycles; abort_at >= 0 deselects while that
  // miso bit index (0 = MSB) is showing
  task automatic serve_read(input logic [7:0] d, input int wait_n, input int abort_at);
    bus.tx_valid = 1'b0;
    repeat (wait_n) begin
      bus.tx_data = 8'($urandom);
      tick();
      chk("wait_miso", bus.miso, 0);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    for (int j = 0; j < 8; j++) begin
      chk("miso_bit", bus.miso, d[7-j]);
      if (j == abort_at) begin
        bus.ss_n = 1'b1;
        tick();
        chk("abort_miso", bus.miso, 0);
        return;
      end
      if (j == 3) bus.tx_valid = 1'b1;  // reload attempt while busy
      tick();
      bus.tx_valid = 1'b0;
    end
    chk("miso_tail", bus.miso, 0);
    bus.tx_valid = 1'b1;  // late tx_valid after the word is sent
    tick();
    bus.tx_valid = 1'b0;
    chk("miso_late_tx", bus.miso, 0);
    tick();
    chk("miso_idle", bus.miso, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    m_rx  = '0;
    m_rad = 1'b0;
    chk("rst_miso", bus.miso, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rd_addr_done", dut.rd_addr_done, 0);
    rst_n    = 1'b1;
    bus.ss_n = 1'b1;
    tick();
  endtask

  initial begin
    bit rd;
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    m_rx  = '0;
    m_rad = 1'b0;
    rst_n = 1'b0;
    tick();
    do_reset();

    // Write frames
    frame(10'h005, 10, rd);
    hold(3);
    gap(1);
    frame(10'h1AA, 10, rd);
    hold(2);
    gap(2);

    // Read address then read data returning 0xAA
    frame(10'h205, 10, rd);
    chk("rd_addr_set", dut.rd_addr_done, 1);
    gap(1);
    frame(10'h35C, 10, rd);
    chk("rd_is_data", 32'(rd), 1);
    serve_read(8'hAA, 2, -1);
    chk("rd_addr_clr", dut.rd_addr_done, 0);
    gap(1);

    // Abort of a rd-addr frame after 5 bits
    frame(10'h2F3, 5, rd);
    chk("abort_rad_zero", dut.rd_addr_done, 0);
    gap(1);

    // Deselect mid miso, then a clean reload
    frame(10'h211, 10, rd);
    gap(1);
    frame(10'h3FF, 10, rd);
    serve_read(8'h96, 3, 4);
    gap(1);
    frame(10'h200, 10, rd);
    gap(1);
    frame(10'h300, 10, rd);
    serve_read(8'h3C, 1, -1);
    gap(1);

    // ss_n raised during the rx_valid cycle: no second pulse
    frame(10'h0F0, 10, rd);
    gap(2);

    // Reset mid READ_DATA shifting, and reset with a read address latched
    frame(10'h2AB, 10, rd);
    gap(1);
    frame(10'h3CD, 10, rd);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    chk("pre_rst_miso", bus.miso, 1);
    tick();
    do_reset();
    frame(10'h2AB, 10, rd);
    do_reset();

`ifdef SPI_TX_TIMEOUT_EN
    // No tx_valid for 16 cycles: miso stays low, late tx_valid ignored
    frame(10'h212, 10, rd);
    gap(1);
    frame(10'h334, 10, rd);
    repeat (16) begin
      tick();
      chk("to_miso", bus.miso, 0);
    end
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("to_late_miso", bus.miso, 0);
    end
    chk("to_rad", dut.rd_addr_done, 0);
    gap(1);
`endif

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      int sel;
      logic [9:0] f;
      sel = $urandom_range(0, 3);
      f   = 10'($urandom);
      if (sel == 0) begin
        f[9] = 1'b0;
        frame(f, 10, rd);
        hold($urandom_range(0, 3));
      end else if (sel == 3) begin
        frame(f, $urandom_range(1, 9), rd);
      end else begin
        f[9] = 1'b1;
        frame(f, 10, rd);
        if (rd)
          serve_read(8'($urandom), $urandom_range(1, 4),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1);
      end
      gap($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
